// File: rtl/shift_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_chain_pkg
// Brief    : Shared constants for the shift-chain controller slice.
//            - c_IDLE / c_SHIFT / c_DONE : 2-bit controller state codes.
//            - c_DEFAULT_WIDTH / c_DEFAULT_DEPTH : default word width and
//              chain depth.
// Revision : 1.0 - initial release
// ============================================================================
package shift_chain_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_DEPTH = 2;

endpackage : shift_chain_pkg
`default_nettype wire

// File: rtl/shift_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : shift_stage_chain
// Brief    : DEPTH D flip-flops in series, all clocked together. A bit
//            presented on d appears on q exactly DEPTH rising edges later.
// Ports    : clock   in  1  rising-edge clock
//            reset_n in  1  synchronous active-low clear of every stage
//            d       in  1  serial input into stage 0
//            q       out 1  output of the last stage
// Revision : 1.0 - initial release
// ============================================================================
module shift_stage_chain
    import shift_chain_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] r_stage;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= {r_stage[DEPTH-2:0], d};
                end
            end
        end
    endgenerate

    assign q = r_stage[DEPTH-1];

endmodule : shift_stage_chain
`default_nettype wire

// File: rtl/shift_chain_controller.sv
`default_nettype none
// ============================================================================
// Module   : shift_chain_controller
// Brief    : Takes a parallel word over a valid/ready handshake, streams it
//            LSB-first through a DEPTH-stage flop chain, rebuilds the word
//            from the chain tail and offers it over a second handshake.
// Ports    : clock      in  1      rising-edge clock
//            reset_n    in  1      synchronous active-low reset
//            in_valid   in  1      producer offers in_data
//            in_ready   out 1      controller accepts in_data (IDLE only)
//            in_data    in  WIDTH  word to serialise
//            ser_d      out 1      bit driven into chain stage 0
//            busy       out 1      accept .. output handshake in progress
//            out_valid  out 1      out_data valid, held until out_ready
//            out_ready  in  1      consumer takes out_data
//            out_data   out WIDTH  rebuilt word
//            out_parity out 1      ^out_data (only with CHAIN_PARITY_EN)
// Config   : define CHAIN_PARITY_EN to add the out_parity port.
// Revision : 1.0 - initial release
// ============================================================================
module shift_chain_controller
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_d,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef CHAIN_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam int CNT_W = $clog2(WIDTH + DEPTH + 1);

    // Timeline (k = SHIFT edge number, r_cnt = k-1 before edge k):
    //   edge k, k=1..WIDTH   : ser_d <= bit k-1
    //   edge k, k>=DEPTH+2   : chain tail carries bit k-DEPTH-2, captured
    //   edge WIDTH+DEPTH+1   : last capture, out_valid rises
    localparam logic [CNT_W-1:0] c_CNT_DRIVE = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_CAP   = CNT_W'(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(WIDTH + DEPTH);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_out_data;
    logic             r_ser_d;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_out_valid;
    logic             w_chain_q;
    logic [WIDTH-1:0] w_out_next;
`ifdef CHAIN_PARITY_EN
    logic             r_parity;
`endif

    shift_stage_chain #(
        .DEPTH (DEPTH)
    ) u_chain (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (r_ser_d),
        .q       (w_chain_q)
    );

    // Tail enters at the MSB; after WIDTH captures bit 0 has reached the LSB.
    assign w_out_next = {w_chain_q, r_out_data[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_out_data  <= '0;
            r_ser_d     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef CHAIN_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid) begin
                        r_sr       <= in_data;
                        r_cnt      <= '0;
                        r_state    <= c_SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                c_SHIFT: begin
                    if (r_cnt < c_CNT_DRIVE) begin
                        r_ser_d <= r_sr[0];
                        r_sr    <= r_sr >> 1;
                    end else begin
                        r_ser_d <= 1'b0;
                    end

                    if (r_cnt >= c_CNT_CAP) begin
                        r_out_data <= w_out_next;
`ifdef CHAIN_PARITY_EN
                        r_parity   <= ^w_out_next;
`endif
                    end

                    // Hold the counter on the final edge so it never wraps.
                    if (r_cnt == c_CNT_LAST) begin
                        r_state     <= c_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end

                default: begin
                    r_state     <= c_IDLE;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_ser_d     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ser_d     = r_ser_d;
`ifdef CHAIN_PARITY_EN
    assign out_parity = r_parity;
`endif

endmodule : shift_chain_controller
`default_nettype wire
